// File: rtl/pu_msp430_dbg_pkg.sv
// Debug memory controller shared definitions: register map, MEM_CTL bit fields, FSM states.
package pu_msp430_dbg_pkg;

    localparam logic [5:0] MEM_CTL_A  = 6'h05;
    localparam logic [5:0] MEM_ADDR_A = 6'h06;
    localparam logic [5:0] MEM_DATA_A = 6'h07;
    localparam logic [5:0] MEM_CNT_A  = 6'h08;

    localparam int CTL_START = 0;
    localparam int CTL_WR    = 1;
    localparam int CTL_REG   = 2;
    localparam int CTL_BW    = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAP  = 2'd2
    } mem_state_e;

    // Byte accesses return the addressed byte zero-extended in the low lane.
    function automatic logic [15:0] byte_sel(input logic [15:0] d, input logic bw, input logic a0);
        logic [15:0] r;
        r = d;
        if (bw) r = a0 ? {8'h00, d[15:8]} : {8'h00, d[7:0]};
        return r;
    endfunction

endpackage

// File: rtl/pu_msp430_dbg_mem_fsm.sv
// Single-access sequencer: one REQ cycle carrying the strobes, then CAP for reads.
// Latency: strobes one cycle after start_i, read data captured two cycles after start_i.
module pu_msp430_dbg_mem_fsm
    import pu_msp430_dbg_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        wr_i,
    input  logic        reg_i,
    input  logic        bw_i,
    input  logic        halt_i,
    input  logic        addr0_i,
    input  logic [15:0] mem_din_i,
    input  logic [15:0] reg_din_i,
    output mem_state_e  state_o,
    output logic        cap_vld_o,
    output logic [15:0] cap_dat_o,
    output logic        wr_done_o,
    output logic        mem_en_o,
    output logic [1:0]  mem_wr_o,
    output logic        reg_wr_o
);

    mem_state_e state_q, state_d;
    logic       blocked_q, blocked_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            blocked_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            blocked_q <= blocked_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        blocked_d = blocked_q;
        cap_vld_o = 1'b0;
        cap_dat_o = 16'h0000;
        wr_done_o = 1'b0;
        mem_en_o  = 1'b0;
        mem_wr_o  = 2'b00;
        reg_wr_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = REQ;
            end
            REQ: begin
                // A register access with the CPU running keeps its timing but touches nothing.
                blocked_d = reg_i & ~halt_i;
                if (!reg_i) begin
                    mem_en_o = 1'b1;
                    if (wr_i) mem_wr_o = bw_i ? (addr0_i ? 2'b10 : 2'b01) : 2'b11;
                end else if (wr_i && halt_i) begin
                    reg_wr_o = 1'b1;
                end
                wr_done_o = wr_i;
                state_d   = wr_i ? IDLE : CAP;
            end
            CAP: begin
                cap_vld_o = 1'b1;
                if (!blocked_q) cap_dat_o = byte_sel(reg_i ? reg_din_i : mem_din_i, bw_i, addr0_i);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: rtl/pu_msp430_dbg_mem_ctl.sv
// Debug MEM_CTL/ADDR/DATA/CNT register block with single and burst access launch.
// Read data returns one cycle after dbg_rd (or after CAP in a read burst); strobes during an access are dropped.
module pu_msp430_dbg_mem_ctl
    import pu_msp430_dbg_pkg::*;
#(
    parameter int MEM_CNT_W = 16
) (
    input  logic        dbg_clk,
    input  logic        dbg_rst_n,
    input  logic [5:0]  dbg_addr,
    input  logic [15:0] dbg_din,
    input  logic        dbg_wr,
    input  logic        dbg_rd,
    input  logic        dbg_halt_st,
    input  logic [15:0] dbg_mem_din,
    input  logic [15:0] dbg_reg_din,
    output logic [15:0] dbg_dout,
    output logic        dbg_rd_rdy,
    output logic        mem_burst,
    output logic        mem_burst_end,
    output logic        mem_burst_rd,
    output logic        mem_burst_wr,
    output logic        mem_bw,
    output logic [15:0] dbg_mem_addr,
    output logic [15:0] dbg_mem_dout,
    output logic        dbg_mem_en,
    output logic [1:0]  dbg_mem_wr,
    output logic        dbg_reg_wr
);

    logic                 ctl_wr_q, ctl_wr_d;
    logic                 ctl_reg_q, ctl_reg_d;
    logic                 ctl_bw_q, ctl_bw_d;
    logic [15:0]          addr_q, addr_d;
    logic [15:0]          data_q, data_d;
    logic [MEM_CNT_W-1:0] cnt_q, cnt_d;
    logic                 burst_q, burst_d;
    logic [15:0]          dout_q, dout_d;
    logic                 rdy_q, rdy_d;
    logic                 brd_q, brd_d;
    logic                 bwr_q, bwr_d;

    mem_state_e  fsm_state;
    logic        fsm_start;
    logic        cap_vld, wr_done;
    logic [15:0] cap_dat;

    logic        fsm_idle, busy, cnt_zero;
    logic        wr_burst, rd_burst;
    logic [15:0] inc;

    assign fsm_idle = (fsm_state == IDLE);
    assign busy     = ~fsm_idle | burst_q;
    assign cnt_zero = (cnt_q == '0);
    assign wr_burst = burst_q & ctl_wr_q;
    assign rd_burst = burst_q & ~ctl_wr_q;
    assign inc      = ctl_bw_q ? 16'd1 : 16'd2;

    always_comb begin
        ctl_wr_d  = ctl_wr_q;
        ctl_reg_d = ctl_reg_q;
        ctl_bw_d  = ctl_bw_q;
        addr_d    = addr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        burst_d   = burst_q;
        dout_d    = dout_q;
        rdy_d     = 1'b0;
        brd_d     = 1'b0;
        bwr_d     = 1'b0;
        fsm_start = 1'b0;

        if (dbg_wr && fsm_idle) begin
            if (wr_burst) begin
                // Inside a write burst every strobe is payload, whatever the address.
                data_d    = dbg_din;
                fsm_start = 1'b1;
            end else begin
                case (dbg_addr)
                    MEM_CTL_A: begin
                        if (!(dbg_din[CTL_START] && busy)) begin
                            ctl_wr_d  = dbg_din[CTL_WR];
                            ctl_reg_d = dbg_din[CTL_REG];
                            ctl_bw_d  = dbg_din[CTL_BW];
                            if (dbg_din[CTL_START]) begin
                                if (cnt_zero) begin
                                    fsm_start = 1'b1;
                                end else begin
                                    burst_d = 1'b1;
                                    if (dbg_din[CTL_WR]) begin
                                        bwr_d = 1'b1;
                                    end else begin
                                        brd_d     = 1'b1;
                                        fsm_start = 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    MEM_ADDR_A: addr_d = dbg_din;
                    MEM_DATA_A: data_d = dbg_din;
                    MEM_CNT_A:  cnt_d  = dbg_din[MEM_CNT_W-1:0];
                    default: ;
                endcase
            end
        end

        if (dbg_rd && fsm_idle) begin
            if (rd_burst) begin
                if (cnt_zero) begin
                    burst_d = 1'b0;
                end else begin
                    cnt_d     = cnt_q - MEM_CNT_W'(1);
                    addr_d    = addr_q + inc;
                    fsm_start = 1'b1;
                end
            end else begin
                rdy_d = 1'b1;
                case (dbg_addr)
                    MEM_CTL_A:  dout_d = {12'h000, ctl_bw_q, ctl_reg_q, ctl_wr_q, busy};
                    MEM_ADDR_A: dout_d = addr_q;
                    MEM_DATA_A: dout_d = data_q;
                    MEM_CNT_A:  dout_d = 16'(cnt_q);
                    default:    dout_d = 16'h0000;
                endcase
            end
        end

        if (cap_vld) begin
            data_d = cap_dat;
            if (rd_burst) begin
                dout_d = cap_dat;
                rdy_d  = 1'b1;
            end
        end

        // Advance only after the write lands so MEM_ADDR ends on the last word written.
        if (wr_done && wr_burst) begin
            if (cnt_zero) begin
                burst_d = 1'b0;
            end else begin
                cnt_d  = cnt_q - MEM_CNT_W'(1);
                addr_d = addr_q + inc;
            end
        end
    end

    always_ff @(posedge dbg_clk or negedge dbg_rst_n) begin
        if (!dbg_rst_n) begin
            ctl_wr_q  <= 1'b0;
            ctl_reg_q <= 1'b0;
            ctl_bw_q  <= 1'b0;
            addr_q    <= 16'h0000;
            data_q    <= 16'h0000;
            cnt_q     <= '0;
            burst_q   <= 1'b0;
            dout_q    <= 16'h0000;
            rdy_q     <= 1'b0;
            brd_q     <= 1'b0;
            bwr_q     <= 1'b0;
        end else begin
            ctl_wr_q  <= ctl_wr_d;
            ctl_reg_q <= ctl_reg_d;
            ctl_bw_q  <= ctl_bw_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            burst_q   <= burst_d;
            dout_q    <= dout_d;
            rdy_q     <= rdy_d;
            brd_q     <= brd_d;
            bwr_q     <= bwr_d;
        end
    end

    pu_msp430_dbg_mem_fsm u_fsm (
        .clk_i     (dbg_clk),
        .rst_n_i   (dbg_rst_n),
        .start_i   (fsm_start),
        .wr_i      (ctl_wr_q),
        .reg_i     (ctl_reg_q),
        .bw_i      (ctl_bw_q),
        .halt_i    (dbg_halt_st),
        .addr0_i   (addr_q[0]),
        .mem_din_i (dbg_mem_din),
        .reg_din_i (dbg_reg_din),
        .state_o   (fsm_state),
        .cap_vld_o (cap_vld),
        .cap_dat_o (cap_dat),
        .wr_done_o (wr_done),
        .mem_en_o  (dbg_mem_en),
        .mem_wr_o  (dbg_mem_wr),
        .reg_wr_o  (dbg_reg_wr)
    );

    assign dbg_dout      = dout_q;
    assign dbg_rd_rdy    = rdy_q;
    assign mem_burst     = burst_q;
    assign mem_burst_end = burst_q & cnt_zero;
    assign mem_burst_rd  = brd_q;
    assign mem_burst_wr  = bwr_q;
    assign mem_bw        = ctl_bw_q;
    assign dbg_mem_addr  = addr_q;
    assign dbg_mem_dout  = ctl_bw_q ? {data_q[7:0], data_q[7:0]} : data_q;

endmodule

// File: tb/tb_pu_msp430_dbg_mem_ctl.sv
// Directed-vector bench for the debug memory controller: one table row per clock, plus a reset-mid-burst sequence.
module tb_pu_msp430_dbg_mem_ctl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  dbg_addr = '0;
    logic [15:0] dbg_din = '0;
    logic        dbg_wr = 1'b0, dbg_rd = 1'b0, dbg_halt_st = 1'b0;
    logic [15:0] dbg_mem_din = '0;
    logic [15:0] dbg_reg_din = 16'h5555;
    logic [15:0] dbg_dout, dbg_mem_addr, dbg_mem_dout;
    logic        dbg_rd_rdy, mem_burst, mem_burst_end, mem_burst_rd, mem_burst_wr, mem_bw;
    logic        dbg_mem_en, dbg_reg_wr;
    logic [1:0]  dbg_mem_wr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pu_msp430_dbg_mem_ctl #(.MEM_CNT_W(16)) dut (
        .dbg_clk(clk), .dbg_rst_n(rst_n), .dbg_addr(dbg_addr), .dbg_din(dbg_din),
        .dbg_wr(dbg_wr), .dbg_rd(dbg_rd), .dbg_halt_st(dbg_halt_st),
        .dbg_mem_din(dbg_mem_din), .dbg_reg_din(dbg_reg_din),
        .dbg_dout(dbg_dout), .dbg_rd_rdy(dbg_rd_rdy), .mem_burst(mem_burst),
        .mem_burst_end(mem_burst_end), .mem_burst_rd(mem_burst_rd), .mem_burst_wr(mem_burst_wr),
        .mem_bw(mem_bw), .dbg_mem_addr(dbg_mem_addr), .dbg_mem_dout(dbg_mem_dout),
        .dbg_mem_en(dbg_mem_en), .dbg_mem_wr(dbg_mem_wr), .dbg_reg_wr(dbg_reg_wr)
    );

    typedef struct {
        logic        wr, rd;
        logic [5:0]  addr;
        logic [15:0] din;
        logic        halt;
        logic [15:0] mdin;
        logic        en;
        logic [1:0]  mwr;
        logic [15:0] maddr, mdout;
        logic        regwr, rdy;
        logic [15:0] dout;
        logic        burst, bend, brd, bwr, bw;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wr, input logic rd, input logic [5:0] addr, input logic [15:0] din,
                       input logic halt, input logic [15:0] mdin,
                       input logic en, input logic [1:0] mwr, input logic [15:0] maddr,
                       input logic [15:0] mdout, input logic regwr, input logic rdy,
                       input logic [15:0] dout, input logic burst, input logic bend,
                       input logic brd, input logic bwr, input logic bw);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.din = din; v.halt = halt; v.mdin = mdin;
        v.en = en; v.mwr = mwr; v.maddr = maddr; v.mdout = mdout; v.regwr = regwr;
        v.rdy = rdy; v.dout = dout; v.burst = burst; v.bend = bend; v.brd = brd;
        v.bwr = bwr; v.bw = bw;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [5:0] addr,
                         input logic [15:0] din, input logic halt, input logic [15:0] mdin);
        dbg_wr = wr; dbg_rd = rd; dbg_addr = addr; dbg_din = din;
        dbg_halt_st = halt; dbg_mem_din = mdin;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_en"}, -1, 16'(dbg_mem_en), 16'h0);
        chk({tag, "_mwr"}, -1, 16'(dbg_mem_wr), 16'h0);
        chk({tag, "_regwr"}, -1, 16'(dbg_reg_wr), 16'h0);
        chk({tag, "_rdy"}, -1, 16'(dbg_rd_rdy), 16'h0);
        chk({tag, "_dout"}, -1, dbg_dout, 16'h0);
        chk({tag, "_burst"}, -1, 16'(mem_burst), 16'h0);
        chk({tag, "_bend"}, -1, 16'(mem_burst_end), 16'h0);
        chk({tag, "_brd"}, -1, 16'(mem_burst_rd), 16'h0);
        chk({tag, "_bwr"}, -1, 16'(mem_burst_wr), 16'h0);
        chk({tag, "_bw"}, -1, 16'(mem_bw), 16'h0);
        chk({tag, "_maddr"}, -1, dbg_mem_addr, 16'h0);
        chk({tag, "_mdout"}, -1, dbg_mem_dout, 16'h0);
    endtask

    initial begin
        // wr rd addr din halt mdin | en mwr maddr mdout regwr rdy dout burst bend brd bwr bw
        // Single word write at 0x0200
        add(1,0,6'h06,16'h0200,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        add(1,0,6'h07,16'hBEEF,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        add(1,0,6'h05,16'h0003,0,16'h0000, 1,2'b11,16'h0200,16'hBEEF,0,0,16'h0,0,0,0,0,0);
        add(0,0,6'h00,16'h0000,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        add(0,1,6'h05,16'h0000,0,16'h0000, 0,2'b00,16'h0,16'h0,0,1,16'h0002,0,0,0,0,0);
        // Byte read at 0x0201
        add(1,0,6'h06,16'h0201,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        add(1,0,6'h05,16'h0009,0,16'h0000, 1,2'b00,16'h0201,16'hEFEF,0,0,16'h0,0,0,0,0,1);
        add(0,0,6'h00,16'h0000,0,16'h12AB, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,1);
        add(0,0,6'h00,16'h0000,0,16'h12AB, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,1);
        add(0,1,6'h07,16'h0000,0,16'h0000, 0,2'b00,16'h0,16'h0,0,1,16'h0012,0,0,0,0,1);
        // Word read burst, three accesses from 0x1000
        add(1,0,6'h06,16'h1000,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,1);
        add(1,0,6'h08,16'h0002,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,1);
        add(1,0,6'h05,16'h0001,0,16'h0000, 1,2'b00,16'h1000,16'h0012,0,0,16'h0,1,0,1,0,0);
        add(0,0,6'h00,16'h0000,0,16'h1111, 0,2'b00,16'h0,16'h0,0,0,16'h0,1,0,0,0,0);
        add(0,0,6'h00,16'h0000,0,16'h1111, 0,2'b00,16'h0,16'h0,0,1,16'h1111,1,0,0,0,0);
        add(1,0,6'h05,16'h0003,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,1,0,0,0,0);
        add(0,1,6'h07,16'h0000,0,16'h0000, 1,2'b00,16'h1002,16'h1111,0,0,16'h0,1,0,0,0,0);
        add(0,0,6'h00,16'h0000,0,16'h2222, 0,2'b00,16'h0,16'h0,0,0,16'h0,1,0,0,0,0);
        add(0,0,6'h00,16'h0000,0,16'h2222, 0,2'b00,16'h0,16'h0,0,1,16'h2222,1,0,0,0,0);
        add(0,1,6'h07,16'h0000,0,16'h0000, 1,2'b00,16'h1004,16'h2222,0,0,16'h0,1,1,0,0,0);
        add(0,0,6'h00,16'h0000,0,16'h3333, 0,2'b00,16'h0,16'h0,0,0,16'h0,1,1,0,0,0);
        add(0,0,6'h00,16'h0000,0,16'h3333, 0,2'b00,16'h0,16'h0,0,1,16'h3333,1,1,0,0,0);
        add(0,1,6'h07,16'h0000,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        add(0,1,6'h06,16'h0000,0,16'h0000, 0,2'b00,16'h0,16'h0,0,1,16'h1004,0,0,0,0,0);
        // Byte write burst wrapping 0xFFFF -> 0x0000
        add(1,0,6'h06,16'hFFFF,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        add(1,0,6'h08,16'h0001,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        add(1,0,6'h05,16'h000B,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,1,0,0,1,1);
        add(1,0,6'h00,16'h00A5,0,16'h0000, 1,2'b10,16'hFFFF,16'hA5A5,0,0,16'h0,1,0,0,0,1);
        add(0,0,6'h00,16'h0000,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,1,1,0,0,1);
        add(1,0,6'h00,16'h005A,0,16'h0000, 1,2'b01,16'h0000,16'h5A5A,0,0,16'h0,1,1,0,0,1);
        add(0,0,6'h00,16'h0000,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,1);
        add(0,1,6'h06,16'h0000,0,16'h0000, 0,2'b00,16'h0,16'h0,0,1,16'h0000,0,0,0,0,1);
        // CPU register write to R4, running then halted
        add(1,0,6'h06,16'h0004,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,1);
        add(1,0,6'h07,16'h1234,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,1);
        add(1,0,6'h05,16'h0007,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        add(0,0,6'h00,16'h0000,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        add(1,0,6'h05,16'h0007,1,16'h0000, 0,2'b00,16'h0004,16'h1234,1,0,16'h0,0,0,0,0,0);
        add(0,0,6'h00,16'h0000,1,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        // CPU register read: running returns 0, halted returns register data
        add(1,0,6'h07,16'hFFFF,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        add(1,0,6'h05,16'h0005,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        add(0,0,6'h00,16'h0000,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        add(0,0,6'h00,16'h0000,0,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        add(0,1,6'h07,16'h0000,0,16'h0000, 0,2'b00,16'h0,16'h0,0,1,16'h0000,0,0,0,0,0);
        add(1,0,6'h05,16'h0005,1,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        add(0,0,6'h00,16'h0000,1,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        add(0,0,6'h00,16'h0000,1,16'h0000, 0,2'b00,16'h0,16'h0,0,0,16'h0,0,0,0,0,0);
        add(0,1,6'h07,16'h0000,0,16'h0000, 0,2'b00,16'h0,16'h0,0,1,16'h5555,0,0,0,0,0);
        add(0,1,6'h05,16'h0000,0,16'h0000, 0,2'b00,16'h0,16'h0,0,1,16'h0004,0,0,0,0,0);
        add(0,1,6'h3F,16'h0000,0,16'h0000, 0,2'b00,16'h0,16'h0,0,1,16'h0000,0,0,0,0,0);

        rst_n = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].din, vecs[i].halt, vecs[i].mdin);
            chk("mem_en", i, 16'(dbg_mem_en), 16'(vecs[i].en));
            chk("mem_wr", i, 16'(dbg_mem_wr), 16'(vecs[i].mwr));
            chk("reg_wr", i, 16'(dbg_reg_wr), 16'(vecs[i].regwr));
            chk("rd_rdy", i, 16'(dbg_rd_rdy), 16'(vecs[i].rdy));
            chk("burst", i, 16'(mem_burst), 16'(vecs[i].burst));
            chk("burst_end", i, 16'(mem_burst_end), 16'(vecs[i].bend));
            chk("burst_rd", i, 16'(mem_burst_rd), 16'(vecs[i].brd));
            chk("burst_wr", i, 16'(mem_burst_wr), 16'(vecs[i].bwr));
            chk("mem_bw", i, 16'(mem_bw), 16'(vecs[i].bw));
            if (vecs[i].rdy) chk("dout", i, dbg_dout, vecs[i].dout);
            if (vecs[i].en || vecs[i].regwr) begin
                chk("mem_addr", i, dbg_mem_addr, vecs[i].maddr);
                chk("mem_dout", i, dbg_mem_dout, vecs[i].mdout);
            end
        end

        // Reset asserted while the second read of a burst is in REQ.
        drive(1, 0, 6'h06, 16'h2000, 0, 16'h0);
        drive(1, 0, 6'h08, 16'h0003, 0, 16'h0);
        drive(1, 0, 6'h05, 16'h0001, 0, 16'h0);
        chk("rb_burst", -1, 16'(mem_burst), 16'h1);
        drive(0, 0, 6'h00, 16'h0000, 0, 16'h7777);
        drive(0, 0, 6'h00, 16'h0000, 0, 16'h7777);
        chk("rb_rdy", -1, 16'(dbg_rd_rdy), 16'h1);
        drive(0, 1, 6'h07, 16'h0000, 0, 16'h0);
        chk("rb_en", -1, 16'(dbg_mem_en), 16'h1);
        chk("rb_addr", -1, dbg_mem_addr, 16'h2002);
        dbg_rd = 1'b0;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        check_all_zero("midrst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        drive(1, 0, 6'h05, 16'h0001, 0, 16'h0);
        chk("post_en", -1, 16'(dbg_mem_en), 16'h1);
        chk("post_addr", -1, dbg_mem_addr, 16'h0000);
        chk("post_burst", -1, 16'(mem_burst), 16'h0);
        chk("post_brd", -1, 16'(mem_burst_rd), 16'h0);
        drive(0, 0, 6'h00, 16'h0000, 0, 16'h0);
        drive(0, 0, 6'h00, 16'h0000, 0, 16'h0);
        drive(0, 1, 6'h08, 16'h0000, 0, 16'h0);
        chk("post_cnt_rdy", -1, 16'(dbg_rd_rdy), 16'h1);
        chk("post_cnt", -1, dbg_dout, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pu_msp430_dbg_mem_ctl.md
Name: pu_msp430_dbg_mem_ctl

Overview:
Debug memory/register access controller directly downstream of the debug UART front-end. Decodes the front-end's register-level writes and reads (dbg_addr/dbg_din/dbg_wr/dbg_rd) into the MEM_CTL, MEM_ADDR, MEM_DATA and MEM_CNT registers. Launches single or burst accesses on the CPU debug memory port, and returns read data plus the burst-control handshake (mem_burst*, mem_bw, dbg_rd_rdy) that paces the UART.

Parameters:
MEM_CNT_W, 16, width of MEM_CNT burst counter (max burst = 2^MEM_CNT_W accesses)

Ports:
dbg_clk  in  1  debug clock
dbg_rst_n  in  1  asynchronous active-low reset
dbg_addr  in  6  debug register address from UART
dbg_din  in  16  debug register write data
dbg_wr  in  1  register write strobe (1 cycle)
dbg_rd  in  1  register read strobe (1 cycle)
dbg_halt_st  in  1  CPU halted; register-file access allowed only when 1
dbg_mem_din  in  16  memory read data, valid cycle after dbg_mem_en
dbg_reg_din  in  16  CPU register read data, valid cycle after request
dbg_dout  out  16  read data to UART, valid with dbg_rd_rdy
dbg_rd_rdy  out  1  read data ready pulse
mem_burst  out  1  burst in progress (level)
mem_burst_end  out  1  last burst word in flight (level)
mem_burst_rd  out  1  read-burst start pulse
mem_burst_wr  out  1  write-burst start pulse
mem_bw  out  1  current access byte-width
dbg_mem_addr  out  16  memory address / CPU register number
dbg_mem_dout  out  16  write data to memory/register
dbg_mem_en  out  1  memory access request (1 cycle)
dbg_mem_wr  out  2  byte write enables
dbg_reg_wr  out  1  CPU register write strobe

Behaviour:
- Reset: all outputs 0; MEM_* registers 0; FSM IDLE.
- Register map (package constants): MEM_CTL 0x05, MEM_ADDR 0x06, MEM_DATA 0x07, MEM_CNT 0x08. MEM_CTL bits: [0] START (self-clearing), [1] WR, [2] REG, [3] BW. Read of MEM_CTL returns [0]=busy (FSM!=IDLE or mem_burst).
- Non-burst dbg_rd: dbg_dout registered from addressed register, dbg_rd_rdy pulses next cycle; unmapped addresses read 0.
- FSM: IDLE -> REQ (1 cycle: dbg_mem_en=1 for memory; dbg_reg_wr=1 for register write) -> write: IDLE; read: CAP -> IDLE. CAP loads MEM_DATA; byte reads select byte by addr[0], zero-extended.
- dbg_mem_wr: word 2'b11; byte 2'b01 if addr[0]=0, else 2'b10; 0 for reads/register accesses. Byte write data replicated in both bytes.
- REG=1 with dbg_halt_st=0: access suppressed (no strobes); a read returns 0; FSM timing unchanged.
- START with MEM_CNT=0: single access launched in the cycle after the write. Read result fetched by a later MEM_DATA register read.
- START with MEM_CNT=N>0: mem_burst=1. Write burst: mem_burst_wr pulse, no access. Read burst: mem_burst_rd pulse, first read at MEM_ADDR.
- mem_burst_end = mem_burst & (MEM_CNT==0).
- Read burst: dbg_rd_rdy pulses the cycle after CAP, with dbg_dout=MEM_DATA. Each dbg_rd with CNT!=0: CNT--, ADDR += BW?1:2, then read. dbg_rd with CNT==0: burst ends (mem_burst=0), no access.
- Write burst: each dbg_wr loads MEM_DATA and writes at ADDR (dbg_addr ignored). Afterwards, if CNT!=0: CNT--, ADDR increments; else burst ends.
- MEM_ADDR always ends at the last accessed address. 16-bit address wraps 0xFFFF->0x0000.
- mem_bw = MEM_CTL.BW.
- START while busy: whole MEM_CTL write ignored. dbg_wr/dbg_rd while FSM!=IDLE: ignored.
- Async reset mid-burst: everything cleared immediately; no further strobes.

Decomposition:
- Package pu_msp430_dbg_pkg: register address constants, MEM_CTL bit indices, FSM state enum (IDLE, REQ, CAP).
- One natural sub-module: pu_msp430_dbg_mem_fsm (REQ/CAP sequencing, strobe generation). Register file and burst counter stay in top.

Test Plan:
- Write MEM_ADDR=0x0200, MEM_DATA=0xBEEF, MEM_CTL=0x003 -> one cycle later dbg_mem_en=1, dbg_mem_wr=2'b11, addr 0x0200, dout 0xBEEF; busy clears 1 cycle after.
- Byte read at 0x0201 (MEM_CTL=0x009), dbg_mem_din=0x12AB -> MEM_DATA=0x0012; MEM_DATA read -> dbg_dout 0x0012 with dbg_rd_rdy.
- Read burst ADDR=0x1000, CNT=2, word -> mem_burst_rd pulse; reads at 0x1000/0x1002/0x1004, three dbg_rd_rdy pulses; fourth dbg_rd ends burst; final MEM_ADDR=0x1004, mem_burst_end high from third access.
- Write burst CNT=1, byte, ADDR=0xFFFF -> mem_burst_wr; writes at 0xFFFF (wr=2'b10) then 0x0000 (wr=2'b01); mem_burst drops after second.
- REG write to R4 with dbg_halt_st=0 -> no dbg_reg_wr; with halt=1 -> single dbg_reg_wr, dbg_mem_addr=4.
- Assert dbg_rst_n=0 mid read burst -> all outputs 0 immediately; next START behaves as from reset.
